matrix_symmetrize: RTL and testbench
====================================

Name: matrix_symmetrize

Overview:
- Sequential symmetrizer for square fixed-point matrices: C = (A + A^T)/2.
- Also measures the worst asymmetry |A[i][j] - A[j][i]| and flags it against a tolerance.
- Runs after the covariance update (P = F*P*F^T, P = (I-KH)P) to restore exact symmetry, and to detect numerical drift.
- Same start/busy/done control style as the other math blocks; imports fp_arith_pkg (DATA_WIDTH, FP_ZERO).

Parameters:
- N, 4, matrix dimension (N x N); legal range 2..16.
- ASYM_TOL, 16, asymmetry tolerance in raw LSBs (unsigned); flag set when max asymmetry > ASYM_TOL.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin operation; sampled only in IDLE
- busy  output  1  high while pairs are being processed
- done  output  1  one-cycle pulse when result, max_asym and asym_flag are valid
- matrix_in  input  signed DATA_WIDTH x [N][N]  matrix A; must be held stable from start until done
- matrix_out  output  signed DATA_WIDTH x [N][N]  symmetrized matrix C
- max_asym  output  unsigned DATA_WIDTH+1  max |A[i][j]-A[j][i]| over all i<j
- asym_flag  output  1  max_asym > ASYM_TOL

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; busy=0, done=0, asym_flag=0, max_asym=0.
  - All matrix_out elements = FP_ZERO; counters=0.
  - Reset mid-run aborts immediately; no partial result is retained.
- FSM states: IDLE, SYMM, DONE_STATE.
- IDLE:
  - done=0, busy=0.
  - On start: busy<=1; row=0, col=0; max_asym<=0; asym_flag<=0; go to SYMM.
- SYMM: one upper-triangle pair (i=row, j=col, j>=i) per cycle, in order row 0..N-1, col row..N-1.
  - sum = A[i][j] + A[j][i], sign-extended to DATA_WIDTH+1 bits.
  - avg = sum >>> 1 (arithmetic; floor toward -inf), truncated to DATA_WIDTH. This never overflows.
  - matrix_out[i][j] <= avg and matrix_out[j][i] <= avg in the same cycle. On the diagonal avg = A[i][i] exactly.
  - diff = A[i][j] - A[j][i] in DATA_WIDTH+1 bits signed; mag = |diff| as DATA_WIDTH+1 unsigned (no overflow).
  - If mag > max_asym then max_asym <= mag. Diagonal pairs contribute 0.
  - Index advance: if col<N-1 then col++; else if row<N-1 then row++ and col<=row+1; else go to DONE_STATE.
- DONE_STATE:
  - done<=1 (one cycle), busy<=0.
  - asym_flag <= (max_asym > ASYM_TOL); next state IDLE.
- Latency:
  - SYMM lasts N(N+1)/2 cycles (10 for N=4).
  - With start sampled at edge k, done is high in the cycle after edge k+N(N+1)/2+1.
  - For N=4: done is high during cycle k+11 to k+12, and busy is high for exactly 10 cycles.
- Output validity:
  - max_asym and asym_flag hold their values until the next accepted start clears them.
  - matrix_out elements update progressively during SYMM. They are complete and stable from done onward until the next start.
- Boundary conditions:
  - start while busy or in DONE_STATE: ignored, no restart.
  - start held high continuously: a new run begins in the IDLE cycle after done, giving back-to-back runs separated by one IDLE cycle.
  - matrix_in changing during busy: undefined result (caller's contract); the block does not latch the input.

Test Plan:
- Symmetric A[i][j]=i+j, N=4: start -> C==A; max_asym=0; asym_flag=0; busy high exactly 10 cycles; done a single pulse 11 cycles after the start edge.
- A[0][1]=100, A[1][0]=50, all other elements 0 -> C[0][1]=C[1][0]=75; every other C element 0; max_asym=50; asym_flag=1.
- Negative floor: A[2][3]=-3, A[3][2]=0 -> C[2][3]=C[3][2]=-2; max_asym=3; asym_flag=0.
- Extremes:
  - A[0][3]=A[3][0]=2^(W-1)-1 -> C[0][3]=C[3][0]=2^(W-1)-1.
  - A[1][2]=2^(W-1)-1, A[2][1]=-2^(W-1) -> C[1][2]=C[2][1]=-1; max_asym=2^W-1; asym_flag=1.
- Control:
  - Pulse start again mid-run -> ignored; done occurs at the original cycle.
  - Assert rst_n=0 mid-run -> busy=0, done=0, outputs FP_ZERO; a subsequent start completes normally with correct result.
- Parameterization N=2, ASYM_TOL=0: A=[[1,2],[3,4]] -> C=[[1,2],[2,4]] (5>>>1=2); max_asym=1; asym_flag=1; busy 3 cycles.

Source files
------------

// File: rtl/matrix_symmetrize.sv
// Symmetrizes a square fixed-point matrix, C = (A + A^T)/2, one upper-triangle
// pair per cycle, and tracks the worst |A[i][j] - A[j][i]| against a tolerance.
package fp_arith_pkg;
  parameter int DATA_WIDTH = 16;
  parameter logic signed [DATA_WIDTH-1:0] FP_ZERO = '0;
endpackage

module matrix_symmetrize
  import fp_arith_pkg::*;
#(
  parameter int          N        = 4,
  parameter int unsigned ASYM_TOL = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  input  logic signed [DATA_WIDTH-1:0] matrix_in  [N][N],
  output logic signed [DATA_WIDTH-1:0] matrix_out [N][N],
  output logic        [DATA_WIDTH:0]   max_asym,
  output logic                         asym_flag
);

  localparam int W  = DATA_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SYMM,
    DONE_STATE
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       row_q, row_d;
  logic [IW-1:0]       col_q, col_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                flag_q, flag_d;
  logic [W:0]          max_q, max_d;
  logic signed [W-1:0] mat_q [N][N];
  logic signed [W-1:0] mat_d [N][N];

  logic signed [W-1:0] a_ij, a_ji;
  logic signed [W:0]   sum, diff;
  logic signed [W-1:0] avg;
  logic [W:0]          mag;

  // Extra bit makes both sum and difference exact; the mirrored read
  // is what lets one cycle cover both halves of the pair.
  always_comb begin
    a_ij = matrix_in[row_q][col_q];
    a_ji = matrix_in[col_q][row_q];
    sum  = {a_ij[W-1], a_ij} + {a_ji[W-1], a_ji};
    diff = {a_ij[W-1], a_ij} - {a_ji[W-1], a_ji};
    avg  = sum[W:1];
    mag  = diff[W] ? $unsigned(-diff) : $unsigned(diff);
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    flag_d  = flag_q;
    max_d   = max_q;
    mat_d   = mat_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          busy_d  = 1'b1;
          row_d   = '0;
          col_d   = '0;
          max_d   = '0;
          flag_d  = 1'b0;
          state_d = SYMM;
        end
      end
      SYMM: begin
        mat_d[row_q][col_q] = avg;
        mat_d[col_q][row_q] = avg;
        if (mag > max_q) max_d = mag;
        if (col_q != IW'(N - 1)) begin
          col_d = col_q + IW'(1);
        end else if (row_q != IW'(N - 1)) begin
          row_d = row_q + IW'(1);
          col_d = row_q + IW'(1);
        end else begin
          busy_d  = 1'b0;
          state_d = DONE_STATE;
        end
      end
      DONE_STATE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        flag_d  = (max_q > (W+1)'(ASYM_TOL));
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      flag_q  <= 1'b0;
      max_q   <= '0;
      mat_q   <= '{default: FP_ZERO};
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      flag_q  <= flag_d;
      max_q   <= max_d;
      mat_q   <= mat_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign asym_flag  = flag_q;
  assign max_asym   = max_q;
  assign matrix_out = mat_q;

endmodule

// File: tb/tb_matrix_symmetrize.sv
// Directed and randomized checks of matrix_symmetrize against an
// arithmetic reference of (A + A^T)/2 and the worst pairwise asymmetry.
module tb_matrix_symmetrize;
  import fp_arith_pkg::*;

  localparam int W = DATA_WIDTH;

  logic clk = 1'b0;
  logic rst_n;
  logic start4, start2;
  logic busy4, busy2, done4, done2, flag4, flag2;
  logic signed [W-1:0] m4 [4][4];
  logic signed [W-1:0] o4 [4][4];
  logic signed [W-1:0] m2 [2][2];
  logic signed [W-1:0] o2 [2][2];
  logic [W:0] max4, max2;

  int tests = 0;
  int failed = 0;
  int a  [16][16];
  int ec [16][16];
  int emax;

  always #5 clk = ~clk;

  matrix_symmetrize #(.N(4), .ASYM_TOL(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4),
    .matrix_in(m4), .matrix_out(o4), .max_asym(max4), .asym_flag(flag4)
  );

  matrix_symmetrize #(.N(2), .ASYM_TOL(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .matrix_in(m2), .matrix_out(o2), .max_asym(max2), .asym_flag(flag2)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_a();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) a[i][j] = 0;
  endtask

  // mode 0: full-range values; mode 1: nearly symmetric small values
  task automatic fill_rand(input int n, input int mode);
    clear_a();
    for (int i = 0; i < n; i++)
      for (int j = i; j < n; j++) begin
        if (mode == 0) begin
          a[i][j] = int'($urandom_range(65535)) - 32768;
          a[j][i] = int'($urandom_range(65535)) - 32768;
        end else begin
          a[i][j] = int'($urandom_range(2000)) - 1000;
          a[j][i] = (i == j) ? a[i][j]
                             : a[i][j] + int'($urandom_range(40)) - 20;
        end
      end
  endtask

  task automatic model(input int n);
    int s, d;
    emax = 0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        s = a[i][j] + a[j][i];
        ec[i][j] = (s >= 0) ? s / 2 : -((-s + 1) / 2);
        d = a[i][j] - a[j][i];
        if (d < 0) d = -d;
        if (i < j && d > emax) emax = d;
      end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) m4[i][j] = W'(a[i][j]);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) m2[i][j] = W'(a[i][j]);
  endtask

  task automatic run(input string tag, input int n, input int tol,
                     input int repulse);
    int busy_cnt, done_cnt, done_at, pairs;
    logic b, d;
    pairs = n * (n + 1) / 2;
    drive();
    model(n);
    if (n == 4) start4 = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    start2 = 1'b0;
    busy_cnt = (n == 4) ? int'(busy4) : int'(busy2);
    done_cnt = 0;
    done_at  = -1;
    for (int c = 1; c <= 30; c++) begin
      if (c == repulse) begin
        if (n == 4) start4 = 1'b1; else start2 = 1'b1;
      end else begin
        start4 = 1'b0;
        start2 = 1'b0;
      end
      @(posedge clk);
      #1;
      b = (n == 4) ? busy4 : busy2;
      d = (n == 4) ? done4 : done2;
      if (b) busy_cnt++;
      if (d) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
    end
    start4 = 1'b0;
    start2 = 1'b0;
    chk({tag, " done_at"}, done_at, pairs + 1);
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " busy_cycles"}, busy_cnt, pairs);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        if (n == 4)
          chk($sformatf("%s C[%0d][%0d]", tag, i, j), o4[i][j], ec[i][j]);
        else
          chk($sformatf("%s C[%0d][%0d]", tag, i, j), o2[i][j], ec[i][j]);
      end
    if (n == 4) begin
      chk({tag, " max_asym"}, max4, emax);
      chk({tag, " asym_flag"}, flag4, (emax > tol) ? 1 : 0);
    end else begin
      chk({tag, " max_asym"}, max2, emax);
      chk({tag, " asym_flag"}, flag2, (emax > tol) ? 1 : 0);
    end
  endtask

  task automatic chk_cleared(input string tag);
    int nz;
    nz = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) if (o4[i][j] !== FP_ZERO) nz++;
    chk({tag, " busy"}, busy4, 0);
    chk({tag, " done"}, done4, 0);
    chk({tag, " max_asym"}, max4, 0);
    chk({tag, " asym_flag"}, flag4, 0);
    chk({tag, " nonzero_out"}, nz, 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start4 = 1'b0;
    start2 = 1'b0;
    clear_a();
    drive();
    #2;
    chk_cleared("reset");
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) a[i][j] = i + j;
    run("sym", 4, 16, 0);

    clear_a();
    a[0][1] = 100;
    a[1][0] = 50;
    run("pair", 4, 16, 0);

    clear_a();
    a[2][3] = -3;
    run("negfloor", 4, 16, 0);

    clear_a();
    a[0][3] = 32767;
    a[3][0] = 32767;
    a[1][2] = 32767;
    a[2][1] = -32768;
    run("extreme", 4, 16, 0);

    for (int k = 0; k < 3; k++) begin
      fill_rand(4, 0);
      run($sformatf("rand%0d", k), 4, 16, 0);
    end
    for (int k = 0; k < 4; k++) begin
      fill_rand(4, 1);
      run($sformatf("near%0d", k), 4, 16, 0);
    end

    fill_rand(4, 1);
    run("restart_ignored", 4, 16, 3);

    fill_rand(4, 0);
    drive();
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_cleared("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("after_reset", 4, 16, 0);

    clear_a();
    a[0][0] = 1;
    a[0][1] = 2;
    a[1][0] = 3;
    a[1][1] = 4;
    run("n2", 2, 0, 0);
    fill_rand(2, 0);
    run("n2rand", 2, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
